// File: rtl/deinterleaver_wifi.sv
// 802.11a/g receive deinterleaver for BPSK/QPSK (s = 1), bit-serial in and out.
// Two ping-pong banks: one symbol is written in channel order while the other is read in encoder order.
module deinterleaver_wifi #(
  parameter int N_CBPS = 48,
  parameter int AW     = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_in,
  input  logic data_in,
  output logic valid_out,
  output logic data_out,
  output logic busy
);

  localparam int R  = N_CBPS / 16;
  localparam int RW = AW - 4;
  localparam logic [RW-1:0] ROW_LAST  = RW'(R - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(N_CBPS - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [3:0]    col;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [1:0]    full_next;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic          wr_last;
  logic          rd_last;

  // Each bank spans the whole address space; only addresses below N_CBPS are ever touched.
  logic mem [2][1<<AW];

  // The write address is {r, c}, i.e. 16*r + c, which is the s = 1 inverse permutation without a multiplier.
  assign wr_addr = {row, col};
  assign wr_last = valid_in && (row == ROW_LAST) && (col == 4'hf);
  assign rd_last = (state == READ) && (rd_addr == ADDR_LAST);

  always_ff @(posedge clk) begin
    if (valid_in) begin
      mem[wr_bank][wr_addr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row     <= '0;
      col     <= '0;
      wr_bank <= 1'b0;
    end else if (valid_in) begin
      if (row == ROW_LAST) begin
        row <= '0;
        if (col == 4'hf) begin
          col     <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          col <= col + 4'd1;
        end
      end else begin
        row <= row + RW'(1);
      end
    end
  end

  // A completing write and a finishing read on opposite banks in one cycle must both land.
  always_comb begin
    full_next = full;
    if (rd_last) begin
      full_next[rd_bank] = 1'b0;
    end
    if (wr_last) begin
      full_next[wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      rd_bank   <= 1'b0;
      full      <= 2'b00;
      valid_out <= 1'b0;
      data_out  <= 1'b0;
    end else begin
      full <= full_next;
      case (state)
        IDLE: begin
          valid_out <= 1'b0;
          data_out  <= 1'b0;
          if (full[rd_bank]) begin
            state   <= READ;
            rd_addr <= '0;
          end
        end
        READ: begin
          valid_out <= 1'b1;
          data_out  <= mem[rd_bank][rd_addr];
          if (rd_addr == ADDR_LAST) begin
            rd_addr <= '0;
            rd_bank <= ~rd_bank;
            // Stay in READ when the other bank is already (or just now) full.
            if (!full_next[~rd_bank]) begin
              state <= IDLE;
            end
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          valid_out <= 1'b0;
          data_out  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (|full) || (row != '0) || (col != 4'h0) || (state == READ);

endmodule
